// File: rtl/jtkcpu_pcu_pkg.sv
// Shared constants and state encodings for the KCPU program counter unit.
// Optional return-address shadow stack is enabled with JTKCPU_PCU_RAS_EN.
package jtkcpu_pcu_pkg;

    localparam int AW_DEF        = 16;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic {
        RUN  = 1'b0,
        PULL = 1'b1
    } pcu_state_t;

endpackage

// File: rtl/jtkcpu_pcu_ras.sv
// Return-address shadow stack: circular, overwrites oldest entry when full.
// Only instantiated when JTKCPU_PCU_RAS_EN is defined.
module jtkcpu_pcu_ras
    import jtkcpu_pcu_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    input  logic [AW-1:0] pop_pc,
    output logic          mis,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] top;
    logic [PW:0]   fill;

    assign top = wp - PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            fill <= '0;
            mis  <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (cen) begin
            mis <= 1'b0;
            if (push) begin
                mem[wp] <= push_pc;
                wp      <= wp + PW'(1);
                // when full, wp already points at the oldest entry
                if (fill == (PW+1)'(DEPTH))
                    ovf <= 1'b1;
                else
                    fill <= fill + (PW+1)'(1);
            end else if (pop) begin
                if (fill == '0) begin
                    unf <= 1'b1;
                end else begin
                    mis  <= mem[top] != pop_pc;
                    wp   <= top;
                    fill <= fill - (PW+1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/jtkcpu_pcu.sv
// KCPU program counter unit: increment, branches, jumps and byte-wise PC pull.
// Define JTKCPU_PCU_RAS_EN to add the return-address shadow stack checker.
module jtkcpu_pcu
    import jtkcpu_pcu_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          inc,
    input  logic          intsrv,
    input  logic          br8,
    input  logic          br16,
    input  logic          take,
    input  logic          jmp,
    input  logic [AW-1:0] jaddr,
    input  logic          up_pc,
    input  logic [15:0]   mdata,
    input  logic          pul_start,
    input  logic          pul_en,
    input  logic          call_push,
    input  logic          ret_chk,
    output logic [AW-1:0] pc,
    output logic          pul_busy,
    output logic          pul_done,
    output logic          ras_mis,
    output logic          ras_ovf,
    output logic          ras_unf
);

    localparam logic [1:0] CNT_TOP = 2'(AW / 8 - 1);

    pcu_state_t    state;
    pcu_state_t    state_n;
    logic [1:0]    cnt;
    logic [1:0]    cnt_n;
    logic          bdone;
    logic          sbr;
    logic          lbr;
    logic          bwr;
    logic [AW-1:0] off8;
    logic [AW-1:0] off16;
    logic [AW-1:0] pc_byte;
    logic [AW-1:0] pc_n;

    assign sbr   = br8 & take;
    assign lbr   = br16 & take;
    assign off8  = AW'(signed'(mdata[7:0]));
    assign off16 = AW'(signed'(mdata));

    // a restart takes the cycle; no byte is written with pul_start
    assign bwr      = (state == PULL) & pul_en & ~pul_start;
    assign pul_busy = state == PULL;
    assign pul_done = cen & ~rst & bwr & (cnt == 2'd0);

    always_comb begin
        pc_byte = pc;
        pc_byte[8*cnt +: 8] = mdata[7:0];
    end

    always_comb begin
        pc_n = pc;
        if (bwr)
            pc_n = pc_byte;
        else if (inc & ~intsrv)
            pc_n = pc + AW'(1);
        else if (state == RUN) begin
            if (sbr & ~bdone)
                pc_n = pc + off8;
            else if (lbr & ~bdone)
                pc_n = pc + off16;
            else if (jmp)
                pc_n = jaddr;
            else if (up_pc)
                pc_n = AW'(mdata);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (pul_start) begin
            state_n = PULL;
            cnt_n   = CNT_TOP;
        end else if (bwr) begin
            if (cnt == 2'd0)
                state_n = RUN;
            else
                cnt_n = cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            state <= RUN;
            cnt   <= 2'd0;
            bdone <= 1'b0;
        end else if (cen) begin
            pc    <= pc_n;
            state <= state_n;
            cnt   <= cnt_n;
            bdone <= sbr | lbr;
        end
    end

`ifdef JTKCPU_PCU_RAS_EN
    jtkcpu_pcu_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .push    (call_push),
        .push_pc (pc),
        .pop     (pul_done & ret_chk),
        .pop_pc  (pc_n),
        .mis     (ras_mis),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = ^{call_push, ret_chk};
    assign ras_mis = 1'b0;
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

endmodule

// File: tb/tb_jtkcpu_pcu.sv
// Directed bench for jtkcpu_pcu (AW=16 and AW=24 instances on shared stimulus).
// Shadow-stack steps run when JTKCPU_PCU_RAS_EN is defined.
module tb_jtkcpu_pcu;

    logic        clk = 1'b0;
    logic        rst, cen, inc, intsrv, br8, br16, take;
    logic        jmp, up_pc, pul_start, pul_en, call_push, ret_chk;
    logic [31:0] jaddr;
    logic [15:0] mdata;

    logic [15:0] pc16;
    logic [23:0] pc24;
    logic busy16, done16, mis16, ovf16, unf16;
    logic busy24, done24, mis24, ovf24, unf24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtkcpu_pcu #(.AW(16)) u16 (
        .clk(clk), .rst(rst), .cen(cen), .inc(inc), .intsrv(intsrv),
        .br8(br8), .br16(br16), .take(take), .jmp(jmp),
        .jaddr(jaddr[15:0]), .up_pc(up_pc), .mdata(mdata),
        .pul_start(pul_start), .pul_en(pul_en),
        .call_push(call_push), .ret_chk(ret_chk),
        .pc(pc16), .pul_busy(busy16), .pul_done(done16),
        .ras_mis(mis16), .ras_ovf(ovf16), .ras_unf(unf16)
    );

    jtkcpu_pcu #(.AW(24)) u24 (
        .clk(clk), .rst(rst), .cen(cen), .inc(inc), .intsrv(intsrv),
        .br8(br8), .br16(br16), .take(take), .jmp(jmp),
        .jaddr(jaddr[23:0]), .up_pc(up_pc), .mdata(mdata),
        .pul_start(pul_start), .pul_en(pul_en),
        .call_push(call_push), .ret_chk(ret_chk),
        .pc(pc24), .pul_busy(busy24), .pul_done(done24),
        .ras_mis(mis24), .ras_ovf(ovf24), .ras_unf(unf24)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cen = 1; rst = 0; inc = 0; intsrv = 0; br8 = 0; br16 = 0;
        take = 0; jmp = 0; up_pc = 0; pul_start = 0; pul_en = 0;
        call_push = 0; ret_chk = 0; jaddr = 0; mdata = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        step();
        rst = 0;
    endtask

    // two-byte pull on the AW=16 instance, flagged as a return
    task automatic ret16(input logic [15:0] addr);
        pul_start = 1;
        step();
        pul_start = 0;
        pul_en = 1;
        mdata = {8'h00, addr[15:8]};
        step();
        mdata = {8'h00, addr[7:0]};
        ret_chk = 1;
        step();
        pul_en = 0;
        ret_chk = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_pc16", pc16, 0);
        chk("rst_pc24", pc24, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done24, 0);
        chk("rst_ras", {mis16, ovf16, unf16}, 0);

        // short branch held 3 cycles adds once
        jmp = 1; jaddr = 32'h1000;
        step();
        jmp = 0;
        chk("jmp", pc16, 16'h1000);
        br8 = 1; take = 1; mdata = 16'h00F0;
        step();
        chk("br8_c1", pc16, 16'h0FF0);
        step();
        chk("br8_c2", pc16, 16'h0FF0);
        step();
        chk("br8_c3", pc16, 16'h0FF0);
        br8 = 0; take = 0;
        step();

        // increment wraps; intsrv blocks inc
        up_pc = 1; mdata = 16'hFFFF;
        step();
        up_pc = 0;
        chk("up_pc", pc16, 16'hFFFF);
        inc = 1;
        step();
        chk("inc_wrap", pc16, 16'h0000);
        intsrv = 1;
        step();
        chk("intsrv", pc16, 16'h0000);
        inc = 0; intsrv = 0;

        // long branch backwards, not-taken, and priorities
        jmp = 1; jaddr = 32'h2000;
        step();
        jmp = 0;
        br16 = 1; take = 1; mdata = 16'h8000;
        step();
        chk("br16", pc16, 16'hA000);
        step();
        chk("br16_hold", pc16, 16'hA000);
        take = 0;
        step();
        step();
        chk("br16_nt", pc16, 16'hA000);
        br16 = 0;
        jmp = 1; jaddr = 32'h4321; up_pc = 1; mdata = 16'h5555;
        step();
        chk("jmp_over_up", pc16, 16'h4321);
        inc = 1;
        step();
        chk("inc_over_jmp", pc16, 16'h4322);
        clr();

        // 24-bit pull, MSB first
        do_reset();
        pul_start = 1;
        step();
        pul_start = 0;
        chk("pull_busy0", busy24, 1);
        pul_en = 1; mdata = 16'h0012;
        #1;
        chk("pull_nodone1", done24, 0);
        step();
        chk("pull_b1", pc24, 24'h120000);
        chk("pull_busy1", busy24, 1);
        mdata = 16'h0034;
        step();
        chk("pull_b2", pc24, 24'h123400);
        chk("pull_busy2", busy24, 1);
        mdata = 16'h0056;
        #1;
        chk("pull_done", done24, 1);
        step();
        chk("pull_b3", pc24, 24'h123456);
        chk("pull_idle", busy24, 0);
        chk("pull_done_end", done24, 0);
        chk("pull16", pc16, 16'h1234);
        pul_en = 0;

        // restart mid-pull; inc only without a byte
        do_reset();
        pul_start = 1;
        step();
        pul_start = 0; pul_en = 1; mdata = 16'h00AA;
        step();
        chk("rs_b1", pc24, 24'hAA0000);
        pul_en = 0; pul_start = 1; inc = 1;
        step();
        chk("rs_inc", pc24, 24'hAA0001);
        pul_start = 0; pul_en = 1; mdata = 16'h00BB;
        step();
        chk("rs_b1again", pc24, 24'hBB0001);
        mdata = 16'h00CC;
        step();
        mdata = 16'h00DD;
        #1;
        chk("rs_done", done24, 1);
        step();
        chk("rs_pc", pc24, 24'hBBCCDD);
        chk("rs_idle", busy24, 0);
        clr();

        // reset during a pull
        do_reset();
        pul_start = 1;
        step();
        pul_start = 0; pul_en = 1; mdata = 16'h0012;
        step();
        rst = 1; mdata = 16'h0034;
        #1;
        chk("rstp_nodone24", done24, 0);
        chk("rstp_nodone16", done16, 0);
        step();
        chk("rstp_pc24", pc24, 0);
        chk("rstp_pc16", pc16, 0);
        chk("rstp_busy", {busy24, busy16}, 0);
        rst = 0; pul_en = 0;
        step();
        chk("rstp_after", {busy24, done24}, 0);

        // clock enable low freezes everything
        do_reset();
        jmp = 1; jaddr = 32'h1234;
        step();
        cen = 0; inc = 1; br8 = 1; br16 = 1; take = 1; jaddr = 32'hBEEF;
        up_pc = 1; pul_start = 1; pul_en = 1; call_push = 1;
        ret_chk = 1; mdata = 16'hFFFF;
        step();
        step();
        chk("cen_pc", pc16, 16'h1234);
        chk("cen_state", {busy16, busy24, done16}, 0);
        chk("cen_ras", {mis16, ovf16, unf16}, 0);
        clr();
        br8 = 1; take = 1; mdata = 16'h0010;
        step();
        chk("cen_bdone", pc16, 16'h1244);
        clr();

        do_reset();
`ifdef JTKCPU_PCU_RAS_EN
        for (int i = 1; i <= 5; i++) begin
            jmp = 1; jaddr = 32'(i * 32'h100);
            step();
            jmp = 0; call_push = 1;
            step();
            call_push = 0;
        end
        chk("ras_ovf", ovf16, 1);
        chk("ras_no_unf", unf16, 0);
        ret16(16'h0500);
        chk("ras_match", mis16, 0);
        ret16(16'h1111);
        chk("ras_mis", mis16, 1);
        step();
        chk("ras_mis_pulse", mis16, 0);
        ret16(16'h0300);
        ret16(16'h0200);
        chk("ras_empty_ok", {mis16, unf16}, 0);
        ret16(16'h0100);
        chk("ras_unf", unf16, 1);
        chk("ras_ovf_sticky", ovf16, 1);
`else
        call_push = 1;
        step();
        call_push = 0;
        ret16(16'h0777);
        chk("ras_off_pc", pc16, 16'h0777);
        chk("ras_off", {mis16, ovf16, unf16}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
